// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way cache controller FSM; flush engine enabled by CACHE_FLUSH_EN

package cache_control_nway_pkg;
    typedef enum logic {CPU_DATA = 1'b0, RAM_DATA = 1'b1} write_data_sel_e;
    typedef enum logic {CPU_EN   = 1'b0, ALL_EN   = 1'b1} write_en_sel_e;
    typedef enum logic {MEM_ADDR = 1'b0, TAG_ADDR = 1'b1} ram_addr_sel_e;
endpackage

module cache_control_nway
    import cache_control_nway_pkg::*;
#(
    parameter  int WAYS = 4,
    parameter  int SETS = 16,
    localparam int WW   = $clog2(WAYS),
    localparam int SW   = $clog2(SETS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            hit,
    input  logic [WW-1:0]   hit_way,
    input  logic [WAYS-1:0] valid_vec,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic [WW-1:0]   lru_way,
    input  logic            ram_resp_o,
    input  logic            flush_req,
    output logic            mem_resp,
    output logic            load,
    output logic            valid,
    output logic            dirty,
    output logic            lru_load,
    output logic [WW-1:0]   way_sel,
    output write_data_sel_e write_data_sel,
    output write_en_sel_e   write_en_sel,
    output ram_addr_sel_e   ram_addr_sel,
    output logic            ram_read_i,
    output logic            ram_write_i,
    output logic            flush_active,
    output logic [SW-1:0]   flush_set,
    output logic            flush_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FETCH     = 3'd3,
        READWRITE = 3'd4,
        FL_CHECK  = 3'd5,
        FL_WB     = 3'd6,
        FL_DONE   = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] victim_q, victim_d;
    logic          victim_dirty;

`ifdef CACHE_FLUSH_EN
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic [WW-1:0] way_cnt_q, way_cnt_d;
    logic          cnt_adv, cnt_clr;
    logic          way_last, set_last, line_dirty;

    assign way_last   = (way_cnt_q == WW'(WAYS - 1));
    assign set_last   = (set_cnt_q == SW'(SETS - 1));
    assign line_dirty = valid_vec[way_cnt_q] & dirty_vec[way_cnt_q];
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req;
`endif

    // Victim choice: first empty way wins, otherwise fall back to the LRU nomination
    always_comb begin
        victim_d = lru_way;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                victim_d = WW'(i);
            end
        end
    end

    assign victim_dirty = valid_vec[victim_d] & dirty_vec[victim_d];

    // State register and victim latch; the victim only changes on a LOOKUP miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOOKUP && !hit) begin
                victim_q <= victim_d;
            end
        end
    end

`ifdef CACHE_FLUSH_EN
    // Flush walk counters: ways inner, sets outer
    always_comb begin
        set_cnt_d = set_cnt_q;
        way_cnt_d = way_cnt_q;
        if (cnt_clr) begin
            set_cnt_d = '0;
            way_cnt_d = '0;
        end else if (cnt_adv) begin
            if (way_last) begin
                way_cnt_d = '0;
                set_cnt_d = set_cnt_q + 1'b1;
            end else begin
                way_cnt_d = way_cnt_q + 1'b1;
            end
        end
    end

    // Flush counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_cnt_q <= '0;
            way_cnt_q <= '0;
        end else begin
            set_cnt_q <= set_cnt_d;
            way_cnt_q <= way_cnt_d;
        end
    end
`endif

    // Next-state and Moore/Mealy outputs; everything idles at zero unless a state drives it
    always_comb begin
        state_d        = state_q;
        mem_resp       = 1'b0;
        load           = 1'b0;
        valid          = 1'b0;
        dirty          = 1'b0;
        lru_load       = 1'b0;
        way_sel        = '0;
        write_data_sel = CPU_DATA;
        write_en_sel   = CPU_EN;
        ram_addr_sel   = MEM_ADDR;
        ram_read_i     = 1'b0;
        ram_write_i    = 1'b0;
        flush_active   = 1'b0;
        flush_set      = '0;
        flush_done     = 1'b0;
`ifdef CACHE_FLUSH_EN
        cnt_adv        = 1'b0;
        cnt_clr        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = LOOKUP;
`ifdef CACHE_FLUSH_EN
                end else if (flush_req) begin
                    state_d = FL_CHECK;
`endif
                end
            end

            LOOKUP: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    way_sel  = hit_way;
                    if (mem_write) begin
                        load  = 1'b1;
                        valid = 1'b1;
                        dirty = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = victim_dirty ? WRITEBACK : FETCH;
                end
            end

            WRITEBACK: begin
                ram_write_i  = 1'b1;
                ram_addr_sel = TAG_ADDR;
                way_sel      = victim_q;
                if (ram_resp_o) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                ram_read_i     = 1'b1;
                load           = 1'b1;
                valid          = 1'b1;
                write_data_sel = RAM_DATA;
                write_en_sel   = ALL_EN;
                way_sel        = victim_q;
                if (ram_resp_o) begin
                    state_d = READWRITE;
                end
            end

            READWRITE: begin
                mem_resp = 1'b1;
                lru_load = 1'b1;
                way_sel  = victim_q;
                if (mem_write) begin
                    load  = 1'b1;
                    valid = 1'b1;
                    dirty = 1'b1;
                end
                state_d = IDLE;
            end

`ifdef CACHE_FLUSH_EN
            FL_CHECK: begin
                flush_active = 1'b1;
                flush_set    = set_cnt_q;
                if (line_dirty) begin
                    state_d = FL_WB;
                end else begin
                    cnt_adv = 1'b1;
                    if (way_last && set_last) begin
                        state_d = FL_DONE;
                    end
                end
            end

            FL_WB: begin
                ram_write_i  = 1'b1;
                ram_addr_sel = TAG_ADDR;
                way_sel      = way_cnt_q;
                if (ram_resp_o) begin
                    // Mark the line clean in place: no byte enables, only state bits
                    load    = 1'b1;
                    valid   = 1'b1;
                    cnt_adv = 1'b1;
                    state_d = (way_last && set_last) ? FL_DONE : FL_CHECK;
                end
            end

            FL_DONE: begin
                flush_done = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = IDLE;
            end
`else
            FL_CHECK, FL_WB, FL_DONE: begin
                state_d = IDLE;
            end
`endif

            default: begin
                mem_resp       = 1'bx;
                load           = 1'bx;
                valid          = 1'bx;
                dirty          = 1'bx;
                lru_load       = 1'bx;
                way_sel        = 'x;
                write_data_sel = write_data_sel_e'(1'bx);
                write_en_sel   = write_en_sel_e'(1'bx);
                ram_addr_sel   = ram_addr_sel_e'(1'bx);
                ram_read_i     = 1'bx;
                ram_write_i    = 1'bx;
                flush_active   = 1'bx;
                flush_set      = 'x;
                flush_done     = 1'bx;
                state_d        = IDLE;
            end
        endcase
    end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 Parameter WAYS, default 4, number of ways; legal values 2, 4, 8; WW = log2(WAYS).
REQ-002 Parameter SETS, default 16, number of sets, power of two; SW = log2(SETS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 mem_read, mem_write  input  1 each  CPU request; held until mem_resp.
REQ-006 hit  input  1  datapath tag match; hit_way  input  WW  matching way.
REQ-007 valid_vec, dirty_vec  input  WAYS each  per-way state of the addressed set.
REQ-008 lru_way  input  WW  way the LRU array nominates for replacement.
REQ-009 ram_resp_o  input  1  memory transfer complete.
REQ-010 flush_req  input  1  request to write back every dirty line.
REQ-011 mem_resp  output  1  one-cycle completion pulse to the CPU.
REQ-012 load, valid, dirty, lru_load  output  1 each  datapath array controls.
REQ-013 way_sel  output  WW  way written or read back by the datapath.
REQ-014 write_data_sel (CPU_DATA/RAM_DATA), write_en_sel (CPU_EN/ALL_EN), ram_addr_sel (MEM_ADDR/TAG_ADDR)  output  enum each.
REQ-015 ram_read_i, ram_write_i  output  1 each  memory requests.
REQ-016 flush_active  output  1; flush_set  output  SW; flush_done  output  1.

Function
REQ-017 States SHALL be IDLE, LOOKUP, WRITEBACK, FETCH, READWRITE, FL_CHECK, FL_WB, FL_DONE.
REQ-018 IDLE: mem_read|mem_write -> LOOKUP; otherwise flush_req -> FL_CHECK. A CPU request wins over a simultaneous flush_req.
REQ-019 LOOKUP hit: assert mem_resp and lru_load and set way_sel=hit_way, then go to IDLE. On a write hit, also assert load, CPU_DATA, CPU_EN, valid and dirty.
REQ-020 LOOKUP miss: latch victim = lowest-index way with valid_vec bit 0, else lru_way. Go to WRITEBACK if the victim is valid and dirty, else FETCH.
REQ-021 WRITEBACK: assert ram_write_i, TAG_ADDR and way_sel=victim; on ram_resp_o go to FETCH.
REQ-022 FETCH: assert ram_read_i, load, RAM_DATA, ALL_EN, valid and way_sel=victim, with dirty=0; on ram_resp_o go to READWRITE.
REQ-023 READWRITE: identical to a LOOKUP hit with way_sel=victim; always go to IDLE.
REQ-024 Miss latency, excluding RAM wait: clean miss 3 cycles to mem_resp, dirty miss 4 cycles.
REQ-025 Victim register SHALL hold its value from LOOKUP until return to IDLE.
REQ-026 FL_CHECK: flush_active=1 and flush_set=set_cnt. If valid_vec[way_cnt] and dirty_vec[way_cnt] are both set, go to FL_WB; otherwise advance the counters.
REQ-027 FL_WB: assert ram_write_i, TAG_ADDR and way_sel=way_cnt. On ram_resp_o, assert load, valid=1 and dirty=0 for that way (write_en_sel=CPU_EN, no data bytes), advance the counters and go to FL_CHECK.
REQ-028 Counter advance: way_cnt increments; when it wraps from WAYS-1 to 0, set_cnt increments. Advancing past way WAYS-1 of set SETS-1 goes to FL_DONE.
REQ-029 FL_DONE: flush_done=1 for one cycle, counters clear, go to IDLE.
REQ-030 CPU requests arriving during a flush SHALL wait; a flush is never aborted except by reset.
REQ-031 Outputs not listed for a state SHALL be 0 or enum value 0; illegal state SHALL drive X and go to IDLE.

Reset
REQ-032 rst low SHALL force IDLE immediately, clear victim, set_cnt and way_cnt, and drive every output to 0 or enum value 0.
REQ-033 Reset during WRITEBACK, FETCH or FL_WB SHALL drop ram_read_i/ram_write_i in the same cycle; the transfer is abandoned.

Configuration
REQ-034 With macro CACHE_FLUSH_EN defined: flush states, counters and REQ-026..030 are present.
REQ-035 Without CACHE_FLUSH_EN: flush_req is ignored; flush_active, flush_set and flush_done are tied to 0; no flush state is reachable.

Verification
REQ-036 WAYS=4, read hit on hit_way=2 -> mem_resp and lru_load in LOOKUP, way_sel=2, load=0.
REQ-037 Read miss, valid_vec=4'b1011 -> victim=2, FETCH with no WRITEBACK, mem_resp 1 cycle after ram_resp_o.
REQ-038 Write miss, valid_vec=4'hF, dirty_vec=4'b0100, lru_way=2 -> WRITEBACK, FETCH, READWRITE with load, dirty=1, CPU_EN, way_sel=2.
REQ-039 SETS=4, WAYS=2, flush with a single dirty line at set 3 way 1 -> exactly one ram_write_i burst, then flush_done after 8 check steps.
REQ-040 mem_read and flush_req rise together -> LOOKUP taken first, flush starts on the next IDLE; reset asserted in FETCH -> ram_read_i=0 that cycle, state IDLE.
